// File: rtl/axis_packet_arbiter_if.sv
// Bundle of every handshake/bus signal around axis_packet_arbiter.
//   master : the arbiter's view (consumes upstream beats, produces the merged stream)
//   slave  : the environment's view (sources, sink and enable control)
// Signals:
//   stream_en      per-stream enable for new grants
//   axis_i_*       NUM_STREAMS upstream AXI-Stream sources, stream i at index i
//   axis_o_*       merged downstream stream plus granted index (axis_o_tid)
//   busy           high while a packet is being passed through
interface axis_packet_arbiter_if #(
  parameter int AXIS_BYTES  = 1,
  parameter int NUM_STREAMS = 3,
  parameter int ID_BITS     = $clog2(NUM_STREAMS)
);
  localparam int DW = AXIS_BYTES * 8;

  logic [NUM_STREAMS-1:0]         stream_en;
  logic [NUM_STREAMS-1:0]         axis_i_tready;
  logic [NUM_STREAMS-1:0]         axis_i_tvalid;
  logic [NUM_STREAMS-1:0]         axis_i_tlast;
  logic [NUM_STREAMS-1:0][DW-1:0] axis_i_tdata;
  logic                           axis_o_tready;
  logic                           axis_o_tvalid;
  logic                           axis_o_tlast;
  logic [DW-1:0]                  axis_o_tdata;
  logic [ID_BITS-1:0]             axis_o_tid;
  logic                           busy;

  modport master (
    input  stream_en, axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_o_tready,
    output axis_i_tready, axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tid, busy
  );

  modport slave (
    output stream_en, axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_o_tready,
    input  axis_i_tready, axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tid, busy
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_STREAMS AXI-Stream sources
// onto one byte-stream output (framer input).
// Ports:
//   clk      clock
//   sresetn  asynchronous active-low reset
//   bus      axis_packet_arbiter_if.master: stream_en, axis_i_* sources,
//            axis_o_* merged output with axis_o_tid, busy
// IDLE arbitrates among valid & enabled sources starting after the last
// winner; PASS connects the winner combinationally until its tlast beat is
// accepted. One IDLE cycle always separates packets.
module axis_packet_arbiter #(
  parameter int AXIS_BYTES  = 1,
  parameter int NUM_STREAMS = 3,
  parameter int ID_BITS     = $clog2(NUM_STREAMS)
) (
  input  logic                   clk,
  input  logic                   sresetn,
  axis_packet_arbiter_if.master  bus
);
  localparam int DW = AXIS_BYTES * 8;

  typedef enum logic {IDLE, PASS} state_t;

  state_t                          state_q, state_d;
  logic [ID_BITS-1:0]              grant_q, grant_d;
  logic [ID_BITS-1:0]              last_grant_q, last_grant_d;
  logic [ID_BITS-1:0]              rr_pick;
  logic                            pass;
  logic                            beat_last;
  logic [NUM_STREAMS-1:0]          sel, req;
  logic [NUM_STREAMS-1:0]          lane_tready, lane_tvalid, lane_tlast;
  logic [NUM_STREAMS-1:0][DW-1:0]  lane_tdata;
  logic [DW-1:0]                   tdata_or;

  assign pass = (state_q == PASS);

  // One-hot lane select; all zero in IDLE so nothing reaches the output.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_STREAMS; i++)
      sel[i] = pass && (grant_q == ID_BITS'(i));
  end

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_lane
    axis_packet_arbiter_lane #(.DW(DW)) u_lane (
      .sel_i      (sel[i]),
      .en_i       (bus.stream_en[i]),
      .tvalid_i   (bus.axis_i_tvalid[i]),
      .tlast_i    (bus.axis_i_tlast[i]),
      .tdata_i    (bus.axis_i_tdata[i]),
      .o_tready_i (bus.axis_o_tready),
      .req_o      (req[i]),
      .tready_o   (lane_tready[i]),
      .tvalid_o   (lane_tvalid[i]),
      .tlast_o    (lane_tlast[i]),
      .tdata_o    (lane_tdata[i])
    );
  end

  // Lanes are zero unless selected, so an OR tree is the output mux.
  always_comb begin
    tdata_or = '0;
    for (int i = 0; i < NUM_STREAMS; i++)
      tdata_or = tdata_or | lane_tdata[i];
  end

  assign bus.axis_i_tready = lane_tready;
  assign bus.axis_o_tvalid = |lane_tvalid;
  assign bus.axis_o_tlast  = |lane_tlast;
  assign bus.axis_o_tdata  = tdata_or;
  assign bus.axis_o_tid    = grant_q;
  assign bus.busy          = pass;

  assign beat_last = bus.axis_o_tvalid & bus.axis_o_tready & bus.axis_o_tlast;

  // Round-robin: distance k=1..N after last_grant; descending scan so the
  // smallest distance with a request is written last and wins. Indices
  // >= NUM_STREAMS never match, so unused tid codes are never granted.
  always_comb begin
    rr_pick = '0;
    for (int k = NUM_STREAMS; k >= 1; k--) begin
      for (int j = 0; j < NUM_STREAMS; j++) begin
        if (req[j] && ((int'(last_grant_q) + k == j) ||
                       (int'(last_grant_q) + k == j + NUM_STREAMS)))
          rr_pick = ID_BITS'(j);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = rr_pick;
          state_d = PASS;
        end
      end
      PASS: begin
        // Grant is frozen here: enables and source gaps are ignored.
        if (beat_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_BITS'(NUM_STREAMS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// Per-stream slice: request qualification and select gating of the
// source's handshake and payload.
module axis_packet_arbiter_lane #(
  parameter int DW = 8
) (
  input  logic          sel_i,
  input  logic          en_i,
  input  logic          tvalid_i,
  input  logic          tlast_i,
  input  logic [DW-1:0] tdata_i,
  input  logic          o_tready_i,
  output logic          req_o,
  output logic          tready_o,
  output logic          tvalid_o,
  output logic          tlast_o,
  output logic [DW-1:0] tdata_o
);
  assign req_o    = tvalid_i & en_i;
  assign tready_o = sel_i & o_tready_i;
  assign tvalid_o = sel_i & tvalid_i;
  assign tlast_o  = sel_i & tlast_i;
  assign tdata_o  = sel_i ? tdata_i : '0;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;
  localparam int NS = 3;
  localparam int AB = 1;

  logic clk = 1'b0;
  logic sresetn = 1'b0;
  always #5 clk = ~clk;

  axis_packet_arbiter_if #(.AXIS_BYTES(AB), .NUM_STREAMS(NS)) bus ();

  axis_packet_arbiter #(.AXIS_BYTES(AB), .NUM_STREAMS(NS)) dut (
    .clk     (clk),
    .sresetn (sresetn),
    .bus     (bus.master)
  );

  logic [NS-1:0]       tv, tl, en;
  logic [NS-1:0][7:0]  td;
  logic                otr;
  assign bus.axis_i_tvalid = tv;
  assign bus.axis_i_tlast  = tl;
  assign bus.axis_i_tdata  = td;
  assign bus.stream_en     = en;
  assign bus.axis_o_tready = otr;

  typedef struct packed {logic v; logic l; logic [7:0] d;} beat_t;
  typedef struct {int t; int d; int c;} log_t;

  beat_t          sq [NS][$];
  log_t           olog[$];
  int             ed[$], et[$], ec[$];
  logic [NS-1:0]  hs = '0;
  logic [NS-1:0]  pres_bub;
  int nchk = 0, nerr = 0, cyc = 0;
  int own = -1, lastg = NS - 1;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int s, input int d, input bit last);
    beat_t b;
    b.v = 1'b1; b.l = last; b.d = 8'(d);
    sq[s].push_back(b);
  endtask

  task automatic push_pkt(input int s, input int base, input int len);
    for (int k = 0; k < len; k++) push_beat(s, base + k, k == len - 1);
  endtask

  task automatic push_bub(input int s, input int n);
    beat_t b;
    b = '0;
    for (int k = 0; k < n; k++) sq[s].push_back(b);
  endtask

  // Source driver: pop a beat once handshaken (or a bubble once shown).
  initial begin
    tv = '0; tl = '0; td = '0; pres_bub = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) begin
        if (sq[i].size() > 0 && (hs[i] || pres_bub[i])) void'(sq[i].pop_front());
        pres_bub[i] = 1'b0;
        if (sq[i].size() == 0) begin
          tv[i] = 1'b0; tl[i] = 1'b0; td[i] = '0;
        end else begin
          tv[i] = sq[i][0].v;
          tl[i] = sq[i][0].l & sq[i][0].v;
          td[i] = sq[i][0].d;
          pres_bub[i] = !sq[i][0].v;
        end
      end
    end
  end

  // Model + per-cycle compare. own = stream holding the output (-1: none).
  logic          exp_v;
  logic [NS-1:0] exp_tr, req;
  int            pick;
  log_t          lt;
  always @(negedge clk) begin
    cyc++;
    hs = tv & bus.axis_i_tready;
    if (!sresetn) begin
      chk("rst_tvalid", int'(bus.axis_o_tvalid), 0);
      chk("rst_tready", int'(bus.axis_i_tready), 0);
      chk("rst_busy",   int'(bus.busy), 0);
      chk("rst_tid",    int'(bus.axis_o_tid), 0);
      own = -1; lastg = NS - 1;
    end else begin
      exp_v  = (own >= 0) ? tv[own] : 1'b0;
      exp_tr = (own >= 0) ? ({{(NS-1){1'b0}}, otr} << own) : '0;
      chk("tvalid", int'(bus.axis_o_tvalid), int'(exp_v));
      chk("tready", int'(bus.axis_i_tready), int'(exp_tr));
      chk("busy",   int'(bus.busy), int'(own >= 0));
      if (own >= 0) chk("tid", int'(bus.axis_o_tid), own);
      if (exp_v) begin
        chk("tdata", int'(bus.axis_o_tdata), int'(td[own]));
        chk("tlast", int'(bus.axis_o_tlast), int'(tl[own]));
      end
      if (bus.axis_o_tvalid && otr) begin
        lt.t = int'(bus.axis_o_tid); lt.d = int'(bus.axis_o_tdata); lt.c = cyc;
        olog.push_back(lt);
      end
      if (own < 0) begin
        req = tv & en;
        pick = -1;
        for (int k = 1; k <= NS; k++)
          if (pick < 0 && req[(lastg + k) % NS]) pick = (lastg + k) % NS;
        own = pick;
      end else if (tv[own] && otr && tl[own]) begin
        lastg = own; own = -1;
      end
    end
  end

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #2;
      done = sq[0].size() == 0 && sq[1].size() == 0 && sq[2].size() == 0 && !bus.busy;
    end
    chk({nm, "_done"}, int'(done), 1);
  endtask

  task automatic wait_log(input int n, input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #2;
      done = olog.size() >= n;
    end
    chk({nm, "_reached"}, int'(done), 1);
  endtask

  task automatic chk_log(input string nm, input int base);
    chk({nm, "_len"}, olog.size() - base, ed.size());
    for (int k = 0; k < ed.size() && base + k < olog.size(); k++) begin
      chk({nm, "_data"}, olog[base+k].d, ed[k]);
      chk({nm, "_tid"},  olog[base+k].t, et[k]);
      if (k < ec.size()) chk({nm, "_cyc"}, olog[base+k].c - olog[base].c, ec[k]);
    end
  endtask

  initial begin
    int b;
    int cnt[NS];
    en = '1; otr = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tvalid_lit", int'(bus.axis_o_tvalid), 0);
    chk("reset_busy_lit",   int'(bus.busy), 0);
    chk("reset_tid_lit",    int'(bus.axis_o_tid), 0);
    sresetn = 1'b1;

    // Three 3-beat packets, one per stream.
    b = olog.size();
    push_pkt(0, 'h10, 3); push_pkt(1, 'h20, 3); push_pkt(2, 'h30, 3);
    wait_idle("t1");
    ed = '{'h10, 'h11, 'h12, 'h20, 'h21, 'h22, 'h30, 'h31, 'h32};
    et = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    ec = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    chk_log("t1", b);

    // Thirty single-beat packets, strict rotation.
    b = olog.size();
    for (int k = 0; k < 10; k++) begin
      push_pkt(0, 'h40 + k, 1); push_pkt(1, 'h50 + k, 1); push_pkt(2, 'h60 + k, 1);
    end
    wait_idle("t2");
    ed.delete(); et.delete(); ec.delete();
    for (int p = 0; p < 30; p++) begin
      ed.push_back('h40 + 'h10 * (p % 3) + p / 3);
      et.push_back(p % 3);
      ec.push_back(2 * p);
    end
    chk_log("t2", b);
    cnt = '{0, 0, 0};
    for (int k = b; k < olog.size(); k++) if (olog[k].t < NS) cnt[olog[k].t]++;
    for (int s = 0; s < NS; s++) chk("t2_count", cnt[s], 10);

    // Backpressure mid-packet on stream 1 while stream 0 requests.
    b = olog.size();
    push_pkt(1, 'h70, 4);
    wait_log(b + 1, "t3a");
    otr = 1'b0;
    push_pkt(0, 'h80, 2);
    repeat (4) begin
      @(posedge clk); #2;
      chk("t3_hold_valid",  int'(bus.axis_o_tvalid), 1);
      chk("t3_hold_tid",    int'(bus.axis_o_tid), 1);
      chk("t3_hold_data",   int'(bus.axis_o_tdata), 'h71);
      chk("t3_hold_tready", int'(bus.axis_i_tready), 0);
    end
    otr = 1'b1;
    wait_idle("t3");
    ed = '{'h70, 'h71, 'h72, 'h73, 'h80, 'h81};
    et = '{1, 1, 1, 1, 0, 0};
    ec = '{0, 5, 6, 7, 9, 10};
    chk_log("t3", b);

    // Enable mask 101, then drop stream 0 mid-packet.
    en = 3'b101;
    b = olog.size();
    push_pkt(0, 'h90, 2); push_pkt(0, 'h92, 2); push_pkt(0, 'h94, 1);
    push_pkt(1, 'hA0, 2);
    push_pkt(2, 'hB0, 2); push_pkt(2, 'hB2, 2); push_pkt(2, 'hB4, 1);
    wait_log(b + 7, "t4a");
    en = 3'b100;
    wait_log(b + 9, "t4b");
    repeat (4) begin
      @(posedge clk); #2;
      chk("t4_disabled_idle", int'(bus.busy), 0);
    end
    en = 3'b111;
    wait_idle("t4");
    ed = '{'hB0, 'hB1, 'h90, 'h91, 'hB2, 'hB3, 'h92, 'h93, 'hB4, 'h94, 'hA0, 'hA1};
    et = '{2, 2, 0, 0, 2, 2, 0, 0, 2, 0, 1, 1};
    ec = '{0, 1, 3, 4, 6, 7, 9, 10, 12};
    chk_log("t4", b);

    // Reset pulse after 2 of 5 beats of stream 2.
    b = olog.size();
    push_pkt(2, 'hC0, 5);
    wait_log(b + 2, "t5a");
    chk("t5_pre_valid", int'(bus.axis_o_tvalid), 1);
    chk("t5_pre_busy",  int'(bus.busy), 1);
    #1 sresetn = 1'b0;
    #1;
    chk("t5_async_valid",  int'(bus.axis_o_tvalid), 0);
    chk("t5_async_busy",   int'(bus.busy), 0);
    chk("t5_async_tready", int'(bus.axis_i_tready), 0);
    chk("t5_async_tid",    int'(bus.axis_o_tid), 0);
    push_pkt(0, 'hD0, 1);
    @(posedge clk); #2;
    sresetn = 1'b1;
    wait_idle("t5");
    ed = '{'hC0, 'hC1, 'hD0, 'hC2, 'hC3, 'hC4};
    et = '{2, 2, 0, 2, 2, 2};
    ec.delete();
    chk_log("t5", b);

    // Source gap on stream 0 while stream 1 waits.
    b = olog.size();
    push_beat(0, 'hE0, 1'b0); push_bub(0, 3);
    push_beat(0, 'hE1, 1'b0); push_beat(0, 'hE2, 1'b1);
    push_pkt(1, 'hF0, 2);
    wait_log(b + 1, "t6a");
    for (int i = 0; i < 3; i++) begin
      chk("t6_gap_valid",  int'(bus.axis_o_tvalid), 0);
      chk("t6_gap_tid",    int'(bus.axis_o_tid), 0);
      chk("t6_gap_tready", int'(bus.axis_i_tready), 1);
      @(posedge clk); #2;
    end
    wait_idle("t6");
    ed = '{'hE0, 'hE1, 'hE2, 'hF0, 'hF1};
    et = '{0, 0, 0, 1, 1};
    ec = '{0, 4, 5, 7, 8};
    chk_log("t6", b);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    nerr++;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
